// File: rtl/light_sequence_monitor.sv
// light_sequence_monitor
//   Passive checker for the traffic-light controller lamp outputs. It decodes
//   {red,yellow,green}, tracks the current phase and checks two things: the legal
//   order Red->Green->Yellow->Red, and the exact dwell time of each phase.
//   Every output is registered; nothing depends combinationally on the lamps.
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   red, yellow, green  lamp inputs from the controller
//   phase               0=SYNC 1=RED 2=GREEN 3=YELLOW
//   in_sync             high whenever phase is not SYNC
//   err, err_code       one-clock error pulse; the cause code holds until the next error
//   err_count           saturating count of errors since reset
//   cycle_count         wrapping count of completed Y->R cycles
//   dwell               clocks the current lamp has been seen, including this one
module light_sequence_monitor #(
   parameter int unsigned RED_TICKS    = 10,
   parameter int unsigned GREEN_TICKS  = 8,
   parameter int unsigned YELLOW_TICKS = 3,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             red,
   input  logic             yellow,
   input  logic             green,
   output logic [1:0]       phase,
   output logic             in_sync,
   output logic             err,
   output logic [2:0]       err_code,
   output logic [7:0]       err_count,
   output logic [7:0]       cycle_count,
   output logic [CNT_W-1:0] dwell
);

   typedef enum logic [1:0] {
      StSync   = 2'd0,
      StRed    = 2'd1,
      StGreen  = 2'd2,
      StYellow = 2'd3
   } phase_e;

   localparam logic [2:0] LampR = 3'b100;
   localparam logic [2:0] LampY = 3'b010;
   localparam logic [2:0] LampG = 3'b001;

   localparam logic [CNT_W-1:0] RedT    = CNT_W'(RED_TICKS);
   localparam logic [CNT_W-1:0] GreenT  = CNT_W'(GREEN_TICKS);
   localparam logic [CNT_W-1:0] YellowT = CNT_W'(YELLOW_TICKS);

   localparam logic [2:0] CodeNone     = 3'd0;
   localparam logic [2:0] CodeNotOneHot = 3'd1;
   localparam logic [2:0] CodeBadOrder = 3'd2;
   localparam logic [2:0] CodeTooShort = 3'd3;
   localparam logic [2:0] CodeTooLong  = 3'd4;

   phase_e           phase_q, phase_d;
   logic [2:0]       lamps_q, lamps_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             err_q, err_d;
   logic [2:0]       err_code_q, err_code_d;
   logic [7:0]       err_count_q, err_count_d;
   logic [7:0]       cycle_count_q, cycle_count_d;

   logic [2:0]       lamps;
   logic             onehot;
   logic [2:0]       cur_lamp;
   logic [2:0]       next_lamp;
   phase_e           next_phase;
   logic [CNT_W-1:0] ticks;
   logic [2:0]       code;

   assign lamps  = {red, yellow, green};
   assign onehot = (lamps == LampR) || (lamps == LampY) || (lamps == LampG);

   // Per-phase lamp, expected successor and required dwell.
   always_comb begin
      cur_lamp   = LampR;
      next_lamp  = LampG;
      next_phase = StGreen;
      ticks      = RedT;
      case (phase_q)
         StGreen: begin
            cur_lamp   = LampG;
            next_lamp  = LampY;
            next_phase = StYellow;
            ticks      = GreenT;
         end
         StYellow: begin
            cur_lamp   = LampY;
            next_lamp  = LampR;
            next_phase = StRed;
            ticks      = YellowT;
         end
         default: ;
      endcase
   end

   always_comb begin
      lamps_d       = lamps;
      phase_d       = phase_q;
      err_d         = 1'b0;
      err_code_d    = err_code_q;
      err_count_d   = err_count_q;
      cycle_count_d = cycle_count_q;
      code          = CodeNone;

      if (lamps != lamps_q) begin
         dwell_d = CNT_W'(1);
      end else if (dwell_q != '1) begin
         dwell_d = dwell_q + CNT_W'(1);
      end else begin
         dwell_d = dwell_q;
      end

      if (phase_q == StSync) begin
         // The red preceding the first green is not timed.
         if (lamps == LampG && lamps_q == LampR) begin
            phase_d = StGreen;
         end
      end else if (!onehot) begin
         code = CodeNotOneHot;
      end else if (lamps == cur_lamp) begin
         // Holding the lamp one more clock would push the dwell past its limit.
         if (dwell_q >= ticks) begin
            code = CodeTooLong;
         end
      end else if (lamps == next_lamp) begin
         if (dwell_q == ticks) begin
            phase_d = next_phase;
            if (phase_q == StYellow) begin
               cycle_count_d = cycle_count_q + 8'd1;
            end
         end else begin
            code = CodeTooShort;
         end
      end else begin
         code = CodeBadOrder;
      end

      if (code != CodeNone) begin
         err_d      = 1'b1;
         err_code_d = code;
         phase_d    = StSync;
         if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q       <= StSync;
         lamps_q       <= 3'b000;
         dwell_q       <= '0;
         err_q         <= 1'b0;
         err_code_q    <= 3'd0;
         err_count_q   <= 8'd0;
         cycle_count_q <= 8'd0;
      end else begin
         phase_q       <= phase_d;
         lamps_q       <= lamps_d;
         dwell_q       <= dwell_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
         err_count_q   <= err_count_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign phase       = phase_q;
   assign in_sync     = (phase_q != StSync);
   assign err         = err_q;
   assign err_code    = err_code_q;
   assign err_count   = err_count_q;
   assign cycle_count = cycle_count_q;
   assign dwell       = dwell_q;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// tb_light_sequence_monitor
//   Directed bench for light_sequence_monitor with hand-computed expectations.
module tb_light_sequence_monitor;

   localparam int unsigned CNT_W = 8;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] RY = 3'b110;
   localparam logic [2:0] NONE = 3'b000;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             red = 1'b0;
   logic             yellow = 1'b0;
   logic             green = 1'b0;
   logic [1:0]       phase;
   logic             in_sync;
   logic             err;
   logic [2:0]       err_code;
   logic [7:0]       err_count;
   logic [7:0]       cycle_count;
   logic [CNT_W-1:0] dwell;

   int n_tests = 0;
   int n_fail  = 0;
   int err_pulses = 0;

   always #5 clk = ~clk;

   light_sequence_monitor #(
      .RED_TICKS   (10),
      .GREEN_TICKS (8),
      .YELLOW_TICKS(3),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .red        (red),
      .yellow     (yellow),
      .green      (green),
      .phase      (phase),
      .in_sync    (in_sync),
      .err        (err),
      .err_code   (err_code),
      .err_count  (err_count),
      .cycle_count(cycle_count),
      .dwell      (dwell)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Present one lamp sample, let it be clocked in, then settle past the edge.
   task automatic step(input logic [2:0] l);
      {red, yellow, green} = l;
      @(posedge clk);
      #1;
      if (err === 1'b1) err_pulses++;
   endtask

   task automatic run(input logic [2:0] l, input int n);
      for (int i = 0; i < n; i++) step(l);
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_phase", phase, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_dwell", dwell, 0);
      reset = 1'b0;

      // 1: three clean R10 G8 Y3 cycles
      run(R, 10);
      check_eq("t1_sync_phase", phase, 0);
      check_eq("t1_red_dwell", dwell, 10);
      check_eq("t1_in_sync0", in_sync, 0);
      step(G);
      check_eq("t1_green_phase", phase, 2);
      check_eq("t1_in_sync1", in_sync, 1);
      check_eq("t1_green_dwell1", dwell, 1);
      run(G, 7);
      check_eq("t1_green_dwell8", dwell, 8);
      step(Y);
      check_eq("t1_yellow_phase", phase, 3);
      run(Y, 2);
      step(R);
      check_eq("t1_red_phase", phase, 1);
      check_eq("t1_cycle1", cycle_count, 1);
      run(R, 9);
      run(G, 8);
      run(Y, 3);
      run(R, 10);
      run(G, 8);
      run(Y, 3);
      check_eq("t1_end_phase", phase, 3);
      check_eq("t1_cycle2", cycle_count, 2);
      check_eq("t1_no_err", err_pulses, 0);
      check_eq("t1_err_count", err_count, 0);

      // 2: green too short
      run(R, 10);
      check_eq("t2_cycle3", cycle_count, 3);
      run(G, 7);
      check_eq("t2_pre_err", err, 0);
      step(Y);
      check_eq("t2_err", err, 1);
      check_eq("t2_code", err_code, 3);
      check_eq("t2_phase", phase, 0);
      check_eq("t2_count", err_count, 1);
      step(Y);
      check_eq("t2_pulse_end", err, 0);
      check_eq("t2_code_hold", err_code, 3);

      // 3: green too long
      step(R);
      step(G);
      check_eq("t3_phase", phase, 2);
      run(G, 7);
      check_eq("t3_ok8", err, 0);
      step(G);
      check_eq("t3_err", err, 1);
      check_eq("t3_code", err_code, 4);
      check_eq("t3_count", err_count, 2);

      // 4: two lamps at once while red, then resync
      step(R);
      step(G);
      run(G, 7);
      run(Y, 3);
      step(R);
      check_eq("t4_red", phase, 1);
      step(RY);
      check_eq("t4_err", err, 1);
      check_eq("t4_code", err_code, 1);
      check_eq("t4_count", err_count, 3);
      err_pulses = 0;
      step(R);
      step(G);
      check_eq("t4_in_sync", in_sync, 1);
      check_eq("t4_no_more_err", err_pulses, 0);

      // 5: green straight to red
      run(G, 7);
      step(R);
      check_eq("t5_err", err, 1);
      check_eq("t5_code", err_code, 2);
      check_eq("t5_count", err_count, 4);

      // 6: reset mid-yellow takes effect without a clock edge
      step(G);
      run(G, 7);
      step(Y);
      step(Y);
      check_eq("t6_yellow", phase, 3);
      reset = 1'b1;
      #1;
      check_eq("t6_rst_phase", phase, 0);
      check_eq("t6_rst_insync", in_sync, 0);
      check_eq("t6_rst_code", err_code, 0);
      check_eq("t6_rst_errcnt", err_count, 0);
      check_eq("t6_rst_cycle", cycle_count, 0);
      check_eq("t6_rst_dwell", dwell, 0);
      check_eq("t6_rst_err", err, 0);
      #1;
      reset = 1'b0;

      // cycle_count wraps 255 -> 0
      step(R);
      for (int i = 0; i < 255; i++) begin
         run(G, 8);
         run(Y, 3);
         run(R, 10);
      end
      check_eq("wrap_255", cycle_count, 255);
      run(G, 8);
      run(Y, 3);
      run(R, 10);
      check_eq("wrap_0", cycle_count, 0);
      check_eq("wrap_phase", phase, 1);
      check_eq("wrap_no_err", err_count, 0);

      // err_count saturates
      step(NONE);
      check_eq("sat_first", err_count, 1);
      for (int i = 0; i < 254; i++) begin
         step(R);
         step(G);
         step(NONE);
      end
      check_eq("sat_255", err_count, 255);
      for (int i = 0; i < 46; i++) begin
         step(R);
         step(G);
         step(NONE);
      end
      check_eq("sat_pulse", err, 1);
      check_eq("sat_hold", err_count, 255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
